seq_adder_subtracter: RTL

//  Parametrised multi-cycle adder/subtracter: WIDTH-bit two's-complement add or subtract
//  of A and B, computed DIGIT bits per clock through a ripple slice with a registered carry.

---
 rtl/seq_adder_subtracter_if.sv | 33 +++
 rtl/seq_adder_subtracter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seq_adder_subtracter_if.sv
// seq_adder_subtracter_if
//  Operand/result bus for seq_adder_subtracter.
//  Request side : in_valid, in_ready, A, B, sub, cin
//  Response side: out_valid, out_ready, S, C, V, Z, N
//  master: the operand source / result sink (drives requests, accepts results)
//  slave : the adder/subtracter itself
interface seq_adder_subtracter_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             C;
  logic             V;
  logic             Z;
  logic             N;

  modport master (
    output in_valid, A, B, sub, cin, out_ready,
    input  in_ready, out_valid, S, C, V, Z, N
  );

  modport slave (
    input  in_valid, A, B, sub, cin, out_ready,
    output in_ready, out_valid, S, C, V, Z, N
  );
endinterface

// File: rtl/seq_adder_subtracter.sv
// seq_adder_subtracter
//  Multi-cycle WIDTH-bit two's-complement adder/subtracter. DIGIT bits are
//  summed per clock through a ripple slice with a registered carry, so an
//  operation takes NCHUNK = WIDTH/DIGIT cycles after it is accepted.
//  Ports:
//    clk   : rising-edge clock
//    reset : asynchronous, active-high reset
//    bus   : seq_adder_subtracter_if.slave
//            in_valid/in_ready handshake with A, B, sub, cin
//            out_valid/out_ready handshake with S and flags C, V, Z, N
//  Optional build macro:
//    SATURATE_EN : on signed overflow S clamps to the most positive/negative
//                  value; C and V stay raw, Z and N follow the clamped S.
module seq_adder_subtracter #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  seq_adder_subtracter_if.slave  bus
);

  localparam int NCHUNK = WIDTH / DIGIT;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("seq_adder_subtracter: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;   // B already inverted for subtraction
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;

  logic [WIDTH-1:0] s_reg;
  logic             c_reg, v_reg, z_reg, n_reg;

  logic [DIGIT-1:0] a_chunk, b_chunk;
  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] acc_n;
  logic             last;
  logic             v_raw;
  logic [WIDTH-1:0] s_fin;

  // Datapath: select the current chunk, add it, and merge the slice into
  // the partial sum so the final edge can register S straight from acc_n.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (cnt == CW'(k)) begin
        a_chunk = a_reg[k*DIGIT +: DIGIT];
        b_chunk = b_reg[k*DIGIT +: DIGIT];
      end
    end
    slice = {1'b0, a_chunk} + {1'b0, b_chunk} + {{DIGIT{1'b0}}, carry};
    acc_n = acc;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (cnt == CW'(k)) begin
        acc_n[k*DIGIT +: DIGIT] = slice[DIGIT-1:0];
      end
    end
    last  = (cnt == CW'(NCHUNK - 1));
    v_raw = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (acc_n[WIDTH-1] != a_reg[WIDTH-1]);
`ifdef SATURATE_EN
    if (v_raw) begin
      s_fin = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      s_fin = acc_n;
    end
`else
    s_fin = acc_n;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.in_valid) state_n = RUN;
      RUN:     if (last)         state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      s_reg <= '0;
      c_reg <= 1'b0;
      v_reg <= 1'b0;
      z_reg <= 1'b0;
      n_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.A;
            b_reg <= bus.B ^ {WIDTH{bus.sub}};
            carry <= bus.sub ? 1'b1 : bus.cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_n;
          carry <= slice[DIGIT];
          cnt   <= cnt + CW'(1);
          if (last) begin
            s_reg <= s_fin;
            c_reg <= slice[DIGIT];
            v_reg <= v_raw;
            z_reg <= (s_fin == '0);
            n_reg <= s_fin[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !reset;
  assign bus.out_valid = (state == DONE);
  assign bus.S         = s_reg;
  assign bus.C         = c_reg;
  assign bus.V         = v_reg;
  assign bus.Z         = z_reg;
  assign bus.N         = n_reg;

endmodule
